// File: rtl/icu_sequencer.sv
// Program sequencer feeding the MC14500B ICU: PC, fetch, return stack.
// Optional halt-on-NOPF support is built when ICU_SEQ_HALT_EN is defined.
module icu_sequencer #(
  parameter int PC_W      = 8,
  parameter int ADDR_W    = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  output logic [PC_W-1:0]                prog_addr,
  input  logic [ADDR_W+3:0]              prog_data,
  output logic [3:0]                     i,
  output logic [ADDR_W-1:0]              io_addr,
  input  logic                           jmp,
  input  logic                           rtn,
  input  logic                           flag_f,
  output logic [$clog2(STK_DEPTH+1)-1:0] sp,
  output logic                           stk_ovf,
  output logic                           stk_unf,
  output logic                           halted
);

  localparam int SP_W  = $clog2(STK_DEPTH + 1);
  localparam int IDX_W =
    (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL =
    SP_W'(STK_DEPTH);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_nx;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   tgt;
  logic [ADDR_W-1:0] op_d1;
  logic [ADDR_W-1:0] operand;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   stk [2**IDX_W];
  logic [SP_W-1:0]   sp_nx;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              push;
  logic              ovf_set;
  logic              unf_set;
  logic              step;

  assign opcode   = prog_data[ADDR_W+3:ADDR_W];
  assign operand  = prog_data[ADDR_W-1:0];
  assign pc_inc   = pc + 1'b1;
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - 1'b1);

  generate
    if (ADDR_W >= PC_W) begin : g_tgt_trunc
      assign tgt = op_d1[PC_W-1:0];
    end else begin : g_tgt_zext
      assign tgt = {{(PC_W-ADDR_W){1'b0}}, op_d1};
    end
  endgenerate

`ifdef ICU_SEQ_HALT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (step && flag_f) begin
      halted <= 1'b1;
    end
  end
`else
  logic unused_flag_f;
  assign unused_flag_f = flag_f;
  assign halted        = 1'b0;
`endif

  assign step = en & ~halted;

  // jmp/rtn refer to the word before the delay slot
  always_comb begin
    pc_nx   = pc_inc;
    sp_nx   = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      jmp & ~rtn: begin
        pc_nx = tgt;
        if (sp == FULL) begin
          ovf_set = 1'b1;
        end else begin
          push  = 1'b1;
          sp_nx = sp + 1'b1;
        end
      end
      rtn & ~jmp: begin
        if (sp == '0) begin
          unf_set = 1'b1;
        end else begin
          pc_nx = stk[pop_idx];
          sp_nx = sp - 1'b1;
        end
      end
      jmp & rtn: pc_nx = tgt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      op_d1   <= '0;
      sp      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      for (int k = 0; k < 2**IDX_W; k++) begin
        stk[k] <= '0;
      end
    end else if (step) begin
      pc    <= pc_nx;
      op_d1 <= operand;
      sp    <= sp_nx;
      if (push)    stk[push_idx] <= pc_inc;
      if (ovf_set) stk_ovf <= 1'b1;
      if (unf_set) stk_unf <= 1'b1;
    end
  end

  assign prog_addr = pc;
  assign i         = (rst && step) ? opcode : 4'h0;
  assign io_addr   = rst ? operand : '0;

endmodule
